// File: rtl/sonar_uc_if.sv
// rtl/sonar_uc_if.sv - strobe/status bundle between sonar_uc and the sonar datapath
interface sonar_uc_if;
    logic       ligar;
    logic       continuo;
    logic       pronto_medida;
    logic       pronto_transmissao;
    logic       fim_serial;
    logic       fim_posicao;
    logic       zera;
    logic       medir;
    logic       partida_serial;
    logic       conta_ascii;
    logic       conta_angulo;
    logic       pronto;
    logic       erro_medida;
    logic [3:0] db_estado;

    modport slave (
        input  ligar, continuo, pronto_medida, pronto_transmissao, fim_serial, fim_posicao,
        output zera, medir, partida_serial, conta_ascii, conta_angulo, pronto, erro_medida,
               db_estado
    );

    modport master (
        output ligar, continuo, pronto_medida, pronto_transmissao, fim_serial, fim_posicao,
        input  zera, medir, partida_serial, conta_ascii, conta_angulo, pronto, erro_medida,
               db_estado
    );
endinterface

// File: rtl/sonar_uc.sv
// rtl/sonar_uc.sv - sonar sweep controller: settle, measure with retry, stream 8-char frame, step servo
module sonar_uc #(
    parameter int INTERVALO      = 100_000_000,
    parameter int TIMEOUT_MEDIDA = 3_000_000,
    parameter int MAX_TENTATIVAS = 3
) (
    input  logic        clock,
    input  logic        reset,
    sonar_uc_if.slave   bus
);
    localparam int CMAX = (INTERVALO > TIMEOUT_MEDIDA) ? INTERVALO : TIMEOUT_MEDIDA;
    localparam int CW   = $clog2(CMAX) + 1;
    localparam int TW   = $clog2(MAX_TENTATIVAS) + 1;

    localparam logic [CW-1:0] INT_LAST  = CW'(INTERVALO - 1);
    localparam logic [CW-1:0] TMO_LAST  = CW'(TIMEOUT_MEDIDA - 1);
    localparam logic [TW-1:0] TENT_LAST = TW'(MAX_TENTATIVAS - 1);

    typedef enum logic [3:0] {
        INICIAL        = 4'd0,
        PREPARA        = 4'd1,
        ESPERA         = 4'd2,
        MEDE           = 4'd3,
        AGUARDA_MEDIDA = 4'd4,
        TRANSMITE      = 4'd5,
        AGUARDA_TX     = 4'd6,
        CONTA_CHAR     = 4'd7,
        PROX_ANGULO    = 4'd8,
        FIM            = 4'd9
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [TW-1:0]   tent_q, tent_d;
    logic            erro_q, erro_d;
    logic            zera_q, medir_q, partida_q, ascii_q, angulo_q, pronto_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tent_d  = tent_q;
        erro_d  = erro_q;
        case (state_q)
            INICIAL: begin
                if (bus.ligar) state_d = PREPARA;
            end
            PREPARA: begin
                erro_d  = 1'b0;
                cnt_d   = '0;
                state_d = ESPERA;
            end
            ESPERA: begin
                tent_d = '0;
                if (!bus.ligar) begin
                    state_d = INICIAL;
                end else if (cnt_q == INT_LAST) begin
                    cnt_d   = '0;
                    state_d = MEDE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            MEDE: begin
                cnt_d   = '0;
                state_d = AGUARDA_MEDIDA;
            end
            AGUARDA_MEDIDA: begin
                cnt_d = cnt_q + 1'b1;
                // A measurement landing on the timeout cycle is accepted, not retried.
                if (bus.pronto_medida) begin
                    state_d = TRANSMITE;
                end else if (cnt_q == TMO_LAST) begin
                    tent_d = tent_q + 1'b1;
                    if (tent_q < TENT_LAST) begin
                        state_d = MEDE;
                    end else begin
                        erro_d  = 1'b1;
                        state_d = TRANSMITE;
                    end
                end
            end
            TRANSMITE: begin
                state_d = AGUARDA_TX;
            end
            AGUARDA_TX: begin
                if (bus.pronto_transmissao) state_d = CONTA_CHAR;
            end
            CONTA_CHAR: begin
                state_d = bus.fim_serial ? PROX_ANGULO : TRANSMITE;
            end
            PROX_ANGULO: begin
                cnt_d   = '0;
                state_d = (bus.fim_posicao && !bus.continuo) ? FIM : ESPERA;
            end
            FIM: begin
                if (!bus.ligar) state_d = INICIAL;
            end
            default: begin
                state_d = INICIAL;
            end
        endcase
    end

    // Strobes are registered from the next state so they line up exactly with state_q.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= INICIAL;
            cnt_q     <= '0;
            tent_q    <= '0;
            erro_q    <= 1'b0;
            zera_q    <= 1'b0;
            medir_q   <= 1'b0;
            partida_q <= 1'b0;
            ascii_q   <= 1'b0;
            angulo_q  <= 1'b0;
            pronto_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            tent_q    <= tent_d;
            erro_q    <= erro_d;
            zera_q    <= (state_d == PREPARA);
            medir_q   <= (state_d == MEDE);
            partida_q <= (state_d == TRANSMITE);
            ascii_q   <= (state_d == CONTA_CHAR);
            angulo_q  <= (state_d == PROX_ANGULO);
            pronto_q  <= (state_d == FIM);
        end
    end

    assign bus.zera           = zera_q;
    assign bus.medir          = medir_q;
    assign bus.partida_serial = partida_q;
    assign bus.conta_ascii    = ascii_q;
    assign bus.conta_angulo   = angulo_q;
    assign bus.pronto         = pronto_q;
    assign bus.erro_medida    = erro_q;
    assign bus.db_estado      = state_q;
endmodule

// File: tb/tb_sonar_uc.sv
// tb/tb_sonar_uc.sv - scoreboard bench for sonar_uc with a behavioural datapath responder
module tb_sonar_uc;
    localparam int INTERVALO = 20;
    localparam int TMO       = 50;
    localparam int MAXT      = 3;

    localparam int EV_Z = 0;
    localparam int EV_M = 1;
    localparam int EV_P = 2;
    localparam int EV_A = 3;
    localparam int EV_G = 4;
    localparam int EV_F = 5;

    logic clock = 1'b0;
    logic reset = 1'b1;

    sonar_uc_if bus();

    sonar_uc #(
        .INTERVALO(INTERVALO),
        .TIMEOUT_MEDIDA(TMO),
        .MAX_TENTATIVAS(MAXT)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus)
    );

    always #5 clock = ~clock;

    typedef struct {
        int kind;
        int delta;
    } ev_t;

    ev_t sb[$];
    int  checks = 0;
    int  errors = 0;
    int  med_delay = 5;
    int  tx_delay  = 10;

    int   med_cd = 0;
    int   tx_cd = 0;
    int   char_cnt = 0;
    int   pos_cnt = 0;
    logic p_z = 1'b0;
    logic p_a = 1'b0;
    logic p_g = 1'b0;

    int   cyc = 0;
    int   last_cyc = 0;
    logic pronto_prev = 1'b0;

    function automatic logic strobe(input int k);
        case (k)
            EV_Z:    return bus.zera;
            EV_M:    return bus.medir;
            EV_P:    return bus.partida_serial;
            EV_A:    return bus.conta_ascii;
            EV_G:    return bus.conta_angulo;
            default: return bus.pronto;
        endcase
    endfunction

    task automatic push(input int k, input int d);
        ev_t e;
        e.kind  = k;
        e.delta = d;
        sb.push_back(e);
    endtask

    // One frame: first partida after the measurement, then 8 x (partida, conta_ascii), then conta_angulo.
    task automatic push_frame(input int first_p);
        for (int i = 0; i < 8; i++) begin
            push(EV_P, (i == 0) ? first_p : 1);
            push(EV_A, 11);
        end
        push(EV_G, 1);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_strobe(input int k, input int budget, input string name);
        int n;
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!strobe(k) && n < budget);
        if (!strobe(k)) begin
            checks++;
            errors++;
            $display("FAIL %s: no event %0d within %0d cycles", name, k, budget);
        end
    endtask

    // Datapath responder: answers medir/partida after fixed delays and keeps char/position counters.
    initial begin : responder
        bus.pronto_medida      = 1'b0;
        bus.pronto_transmissao = 1'b0;
        bus.fim_serial         = 1'b0;
        bus.fim_posicao        = 1'b0;
        forever begin
            @(negedge clock);
            if (reset) begin
                med_cd = 0; tx_cd = 0; char_cnt = 0; pos_cnt = 0;
                p_z = 1'b0; p_a = 1'b0; p_g = 1'b0;
                bus.pronto_medida      = 1'b0;
                bus.pronto_transmissao = 1'b0;
            end else begin
                if (p_z) begin char_cnt = 0; pos_cnt = 0; end
                if (p_a) char_cnt = (char_cnt + 1) % 8;
                if (p_g) pos_cnt = (pos_cnt + 1) % 8;
                bus.pronto_medida = 1'b0;
                if (med_cd > 0) begin
                    med_cd--;
                    if (med_cd == 0) bus.pronto_medida = 1'b1;
                end
                bus.pronto_transmissao = 1'b0;
                if (tx_cd > 0) begin
                    tx_cd--;
                    if (tx_cd == 0) bus.pronto_transmissao = 1'b1;
                end
                if (bus.medir && med_delay > 0) med_cd = med_delay;
                if (bus.partida_serial) tx_cd = tx_delay;
                p_z = bus.zera;
                p_a = bus.conta_ascii;
                p_g = bus.conta_angulo;
            end
            bus.fim_serial  = (char_cnt == 7);
            bus.fim_posicao = (pos_cnt == 7);
        end
    end

    initial begin : monitor
        ev_t e;
        int  d;
        forever begin
            @(negedge clock);
            cyc++;
            for (int k = 0; k < 6; k++) begin
                if ((k == EV_F) ? (bus.pronto && !pronto_prev) : strobe(k)) begin
                    checks++;
                    d = cyc - last_cyc;
                    if (sb.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_event: got kind %0d delta %0d expected none", k, d);
                    end else begin
                        e = sb.pop_front();
                        if (e.kind != k || (e.delta >= 0 && e.delta != d)) begin
                            errors++;
                            $display("FAIL event_seq: got kind %0d delta %0d expected kind %0d delta %0d",
                                     k, d, e.kind, e.delta);
                        end
                    end
                    last_cyc = cyc;
                end
            end
            pronto_prev = bus.pronto;
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        bus.ligar    = 1'b0;
        bus.continuo = 1'b0;
        repeat (2) @(negedge clock);
        chk("reset_estado", bus.db_estado, 0);
        chk("reset_outs", {bus.zera, bus.medir, bus.partida_serial, bus.conta_ascii,
                           bus.conta_angulo, bus.pronto, bus.erro_medida}, 0);
        reset = 1'b0;

        // Single sweep, prompt answers
        push(EV_Z, -1);
        for (int p = 0; p < 8; p++) begin
            push(EV_M, 21);
            push_frame(6);
        end
        push(EV_F, 1);
        bus.ligar = 1'b1;
        wait_strobe(EV_F, 2000, "t1_fim");
        @(negedge clock);
        chk("t1_estado", bus.db_estado, 9);
        chk("t1_pronto", bus.pronto, 1);
        chk("t1_erro", bus.erro_medida, 0);
        chk("t1_sb_empty", sb.size(), 0);
        bus.ligar = 1'b0;
        repeat (2) @(negedge clock);
        chk("t1_inicial", bus.db_estado, 0);

        // Measurement never answered: 3 attempts per position, sticky error
        med_delay = 0;
        push(EV_Z, -1);
        for (int p = 0; p < 8; p++) begin
            push(EV_M, 21);
            push(EV_M, 51);
            push(EV_M, 51);
            push_frame(51);
        end
        push(EV_F, 1);
        bus.ligar = 1'b1;
        wait_strobe(EV_M, 100, "t2_m1");
        wait_strobe(EV_M, 100, "t2_m2");
        wait_strobe(EV_M, 100, "t2_m3");
        chk("t2_erro_before", bus.erro_medida, 0);
        wait_strobe(EV_P, 100, "t2_p1");
        chk("t2_erro_after", bus.erro_medida, 1);
        wait_strobe(EV_F, 4000, "t2_fim");
        @(negedge clock);
        chk("t2_estado", bus.db_estado, 9);
        chk("t2_erro_fim", bus.erro_medida, 1);
        bus.ligar = 1'b0;
        repeat (3) @(negedge clock);
        chk("t2_inicial", bus.db_estado, 0);
        chk("t2_erro_held", bus.erro_medida, 1);

        // Answer lands on the timeout cycle: accepted, no retry
        med_delay = TMO;
        push(EV_Z, -1);
        for (int p = 0; p < 8; p++) begin
            push(EV_M, 21);
            push_frame(51);
        end
        push(EV_F, 1);
        bus.ligar = 1'b1;
        wait_strobe(EV_Z, 10, "t3_zera");
        @(negedge clock);
        chk("t3_erro_cleared", bus.erro_medida, 0);
        wait_strobe(EV_F, 3000, "t3_fim");
        @(negedge clock);
        chk("t3_estado", bus.db_estado, 9);
        chk("t3_erro", bus.erro_medida, 0);
        bus.ligar = 1'b0;
        repeat (2) @(negedge clock);

        // Continuous sweep over 10 positions, ligar dropped mid-frame in the last one
        med_delay    = 5;
        bus.continuo = 1'b1;
        push(EV_Z, -1);
        for (int p = 0; p < 10; p++) begin
            push(EV_M, 21);
            push_frame(6);
        end
        bus.ligar = 1'b1;
        for (int g = 0; g < 8; g++) wait_strobe(EV_G, 300, "t4_angulo");
        @(negedge clock);
        chk("t4_wrap_espera", bus.db_estado, 2);
        chk("t4_no_pronto", bus.pronto, 0);
        wait_strobe(EV_G, 300, "t4_angulo9");
        for (int c = 0; c < 3; c++) wait_strobe(EV_P, 50, "t5_partida");
        @(negedge clock);
        chk("t5_aguarda_tx", bus.db_estado, 6);
        bus.ligar = 1'b0;
        wait_strobe(EV_G, 300, "t5_angulo10");
        @(negedge clock);
        chk("t5_espera", bus.db_estado, 2);
        @(negedge clock);
        chk("t5_inicial", bus.db_estado, 0);
        repeat (60) @(negedge clock);
        chk("t5_stays_inicial", bus.db_estado, 0);
        chk("t5_sb_empty", sb.size(), 0);

        // Asynchronous reset in TRANSMITE
        bus.continuo = 1'b0;
        push(EV_Z, -1);
        push(EV_M, 21);
        push(EV_P, 6);
        bus.ligar = 1'b1;
        wait_strobe(EV_P, 100, "t6_partida");
        #2 reset = 1'b1;
        #1;
        chk("t6_async_estado", bus.db_estado, 0);
        chk("t6_async_outs", {bus.zera, bus.medir, bus.partida_serial, bus.conta_ascii,
                              bus.conta_angulo, bus.pronto, bus.erro_medida}, 0);
        @(negedge clock);
        bus.ligar = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        repeat (5) @(negedge clock);
        chk("t6_hold_inicial", bus.db_estado, 0);
        push(EV_Z, -1);
        push(EV_M, 21);
        bus.ligar = 1'b1;
        wait_strobe(EV_M, 100, "t6_medir");
        reset = 1'b1;
        repeat (10) @(negedge clock);
        chk("t6_final_estado", bus.db_estado, 0);
        chk("t6_sb_empty", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/sonar_uc.md
Name: sonar_uc

Overview:
Control unit for the sonar datapath (servo sweep + HC-SR04 interface + 7E1 serial TX + 8-char ASCII frame mux). For each of 8 servo positions it:
- waits a settling interval;
- triggers one distance measurement, with timeout and retry;
- streams the 8-character frame (3 angle digits, ',', 3 distance digits, '#') one character at a time;
- advances the servo.
It supports single-sweep and continuous modes and drives the datapath's zera/medir/partida/conta strobes.

Parameters:
INTERVALO, 100_000_000, settling wait per position in clock cycles (2 s at 50 MHz); minimum 2.
TIMEOUT_MEDIDA, 3_000_000, max cycles waiting for pronto_medida per attempt; minimum 2.
MAX_TENTATIVAS, 3, measurement attempts per position before giving up; minimum 1.

Ports:
clock  input  1  system clock; all logic on its rising edge.
reset  input  1  asynchronous, active-high; forces the state below.
ligar  input  1  level: 1 = run, 0 = stop at next safe point.
continuo  input  1  1 = sweep forever; 0 = stop after position 7; sampled in PROX_ANGULO.
pronto_medida  input  1  1-cycle pulse from the distance interface: measurement valid.
pronto_transmissao  input  1  1-cycle pulse from the serial TX: character sent.
fim_serial  input  1  character counter at last character (7).
fim_posicao  input  1  position counter at last position (7).
zera  output  1  synchronous clear of datapath counters/registers.
medir  output  1  start measurement pulse.
partida_serial  output  1  start one character transmission.
conta_ascii  output  1  advance character selector (wraps 7->0).
conta_angulo  output  1  advance servo position (wraps 7->0).
pronto  output  1  high in FIM (sweep complete).
erro_medida  output  1  sticky: some position exhausted all attempts.
db_estado  output  4  current state code.

Behaviour:
- Moore FSM. Strobe outputs decode from the state register only; each strobe is high for exactly the cycle(s) spent in its state.
- Internal counters:
  - cnt: cycle counter, width $clog2(max(INTERVALO, TIMEOUT_MEDIDA)) + 1.
  - tent: attempt counter, width $clog2(MAX_TENTATIVAS) + 1.
  - erro: sticky error register.
- Reset: state INICIAL, cnt=0, tent=0, erro=0. All outputs 0, db_estado=0. Reset mid-frame aborts immediately; no partial-frame recovery.
- States (code), output asserted, transition:
  - INICIAL (0): none. ligar=1 -> PREPARA.
  - PREPARA (1): zera=1; clears erro. -> ESPERA.
  - ESPERA (2): cnt counts from 0; tent=0. ligar=0 -> INICIAL. Else, when cnt==INTERVALO-1 -> MEDE. Dwell is exactly INTERVALO cycles.
  - MEDE (3): medir=1 for 1 cycle; cnt cleared. -> AGUARDA_MEDIDA.
  - AGUARDA_MEDIDA (4): cnt++.
    - pronto_medida=1 -> TRANSMITE. If pronto_medida and timeout coincide, pronto wins.
    - Else cnt==TIMEOUT_MEDIDA-1: tent++. If tent+1 < MAX_TENTATIVAS -> MEDE (retry). Otherwise erro<=1 -> TRANSMITE, and the frame carries the stale distance.
  - TRANSMITE (5): partida_serial=1 for 1 cycle. -> AGUARDA_TX.
  - AGUARDA_TX (6): none. pronto_transmissao=1 -> CONTA_CHAR.
  - CONTA_CHAR (7): conta_ascii=1.
    - fim_serial is sampled this cycle, before the increment takes effect.
    - fim_serial=1 -> PROX_ANGULO (selector wraps to 0). Else -> TRANSMITE.
  - PROX_ANGULO (8): conta_angulo=1. fim_posicao=1 and continuo=0 -> FIM. Otherwise -> ESPERA (position wraps 7->0 in continuous mode).
  - FIM (9): pronto=1. ligar=0 -> INICIAL. A new sweep requires ligar to drop and rise again.
- Unused codes 10..15 -> INICIAL on the next clock.
- ligar is checked only in INICIAL/ESPERA/FIM; frames are never truncated by ligar.
- erro_medida = erro register; holds until PREPARA or reset.
- Per position: exactly 1..MAX_TENTATIVAS medir pulses, exactly 8 partida_serial pulses, 8 conta_ascii pulses and 1 conta_angulo pulse.
- Single sweep: 8 conta_angulo pulses total, then FIM.

Test Plan:
1. INTERVALO=20, TIMEOUT=50. reset=1 then 0, ligar=1, continuo=0; medida answered 5 cycles after medir; TX answered 10 cycles after partida -> 1 zera pulse. Per position: first medir exactly 20 cycles after entering ESPERA, 8 partida pulses, then conta_angulo. After 8 positions pronto=1, db_estado=9, erro_medida=0.
2. Never answer pronto_medida, MAX_TENTATIVAS=3 -> medir pulses 51 cycles apart (3 total). erro_medida=1 from the 3rd timeout onward. 8 characters still transmitted. erro cleared only by the next PREPARA.
3. pronto_medida on the same cycle cnt hits TIMEOUT-1 -> goes to TRANSMITE, tent unchanged, no retry, erro_medida stays 0.
4. continuo=1 through 10 positions -> no pronto. After position 7, conta_angulo then ESPERA with fim_posicao=0, and the sweep continues.
5. ligar=0 during AGUARDA_TX of character 3 -> remaining 5 characters sent. Return to INICIAL at the next ESPERA entry. No further medir.
6. Assert reset asynchronously mid-TRANSMITE (between clock edges) -> all outputs 0 and db_estado=0 before the next edge. Resumes only with ligar=1, starting with a zera pulse.
